// File: rtl/multilane_self_sync_descrambler_if.sv
// multilane_self_sync_descrambler_if: 66b block stream in/out of the descrambler
interface multilane_self_sync_descrambler_if #(
  parameter int NUM_LANES = 1
);
  logic [66*NUM_LANES-1:0] data_in;
  logic                    data_valid_in;
  logic                    data_ready_out;
  logic [66*NUM_LANES-1:0] data_out;
  logic [NUM_LANES-1:0]    hdr_err_out;
  logic                    data_valid_out;
  logic                    data_ready_in;
  modport slave (
    input  data_in, data_valid_in, data_ready_in,
    output data_ready_out, data_out, hdr_err_out, data_valid_out
  );
  modport master (
    output data_in, data_valid_in, data_ready_in,
    input  data_ready_out, data_out, hdr_err_out, data_valid_out
  );
endinterface

// File: rtl/multilane_self_sync_descrambler.sv
// multilane_self_sync_descrambler: per-lane x^58+x^39+1 self-synchronising 64b/66b descrambler
// with output register, one-entry skid buffer, bypass and saturating header error count.
module multilane_self_sync_descrambler #(
  parameter int NUM_LANES = 1,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic                 bypass,
  input  logic                 err_cnt_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
  multilane_self_sync_descrambler_if.slave bus
);
  localparam int W  = 66*NUM_LANES;
  localparam int CW = ERR_CNT_W + 4;
  localparam logic [CW-1:0] CMAX = (CW'(1) << ERR_CNT_W) - 1;
  logic                 acc, free, rdy_q;
  logic [W-1:0]         dsc;
  logic [NUM_LANES-1:0] herr;
  logic [W-1:0]         out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [NUM_LANES-1:0] out_err_q, out_err_d, skid_err_q, skid_err_d;
  logic                 out_vld_q, out_vld_d, skid_full_q, skid_full_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]        pc, tot;
  assign acc  = bus.data_valid_in && rdy_q;
  assign free = !out_vld_q || bus.data_ready_in;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [57:0]  st_q, st_d;
    logic [121:0] x;
    logic [63:0]  pay;
    logic [1:0]   hdr;
    assign hdr = bus.data_in[66*k+64 +: 2];
    // x is the received bit stream, oldest state bit first, then the 64 new payload bits
    always_comb begin
      x    = {bus.data_in[66*k +: 64], 58'd0};
      pay  = '0;
      st_d = '0;
      for (int j = 0; j < 58; j++) x[j] = st_q[57-j];
      for (int i = 0; i < 64; i++) pay[i] = x[58+i] ^ x[19+i] ^ x[i];
      for (int j = 0; j < 58; j++) st_d[j] = x[121-j];
    end
    assign herr[k] = hdr[1] ~^ hdr[0];
    assign dsc[66*k +: 66] = {hdr, bypass ? bus.data_in[66*k +: 64] : pay};
    always_ff @(posedge rx_clk or posedge rx_rst)
      if (rx_rst) st_q <= '1;
      else if (acc) st_q <= st_d;
  end
  always_comb begin
    pc = '0;
    for (int k = 0; k < NUM_LANES; k++) pc = pc + CW'(herr[k]);
    tot   = CW'(cnt_q) + pc;
    cnt_d = err_cnt_clr ? '0 : !acc ? cnt_q : tot > CMAX ? ERR_CNT_W'(CMAX) : tot[ERR_CNT_W-1:0];
  end
  always_comb begin
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_vld_d   = out_vld_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    skid_full_d = skid_full_q;
    if (free && skid_full_q) begin
      out_data_d  = skid_data_q;
      out_err_d   = skid_err_q;
      out_vld_d   = 1'b1;
      skid_full_d = 1'b0;
    end else if (free) begin
      out_vld_d = acc;
      if (acc) begin
        out_data_d = dsc;
        out_err_d  = herr;
      end
    end else if (acc) begin
      skid_data_d = dsc;
      skid_err_d  = herr;
      skid_full_d = 1'b1;
    end
  end
  always_ff @(posedge rx_clk or posedge rx_rst)
    if (rx_rst) begin
      out_data_q  <= '0;
      out_err_q   <= '0;
      out_vld_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= '0;
      skid_full_q <= 1'b0;
      rdy_q       <= 1'b1;
      cnt_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_vld_q   <= out_vld_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      skid_full_q <= skid_full_d;
      rdy_q       <= !skid_full_d;
      cnt_q       <= cnt_d;
    end
  assign bus.data_out       = out_data_q;
  assign bus.hdr_err_out    = out_err_q;
  assign bus.data_valid_out = out_vld_q;
  assign bus.data_ready_out = rdy_q;
  assign err_cnt            = cnt_q;
endmodule

// File: tb/tb_multilane_self_sync_descrambler.sv
// tb_multilane_self_sync_descrambler: scoreboard bench with a bit-history reference descrambler
module tb_multilane_self_sync_descrambler;
  localparam int NL = 4;
  localparam int ECW = 4;
  localparam int W = 66*NL;
  localparam int MAXC = (1 << ECW) - 1;
  logic rx_clk = 0, rx_rst = 1, bypass = 0, err_cnt_clr = 0;
  logic [ECW-1:0] err_cnt;
  multilane_self_sync_descrambler_if #(.NUM_LANES(NL)) bus();
  multilane_self_sync_descrambler #(.NUM_LANES(NL), .ERR_CNT_W(ECW)) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .bypass(bypass), .err_cnt_clr(err_cnt_clr),
    .err_cnt(err_cnt), .bus(bus)
  );
  typedef struct { logic [W-1:0] d; logic [NL-1:0] he; bit dc; } exp_t;
  exp_t sb[$];
  exp_t me;
  logic [NL-1:0] rh[$];
  logic [NL-1:0] th[$];
  int n_chk = 0, n_err = 0, occ = 0, cnt_m = 0;
  bit rdy_rand = 0, rdy_force = 1, stall = 0;
  logic [W-1:0] prev_d;
  logic [NL-1:0] prev_h;
  always #5 rx_clk = ~rx_clk;
  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  // reference: each output bit is the received bit xor the received bits 39 and 58 positions earlier
  task automatic model(input logic [W-1:0] d, input logic byp, output logic [W-1:0] e, output logic [NL-1:0] he);
    logic [NL-1:0] b;
    e = d;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < NL; k++) begin
        b[k] = d[66*k+i];
        e[66*k+i] = byp ? b[k] : b[k] ^ rh[rh.size()-39][k] ^ rh[rh.size()-58][k];
      end
      rh.push_back(b);
      void'(rh.pop_front());
    end
    for (int k = 0; k < NL; k++) he[k] = (d[66*k+64 +: 2] == 2'b00) || (d[66*k+64 +: 2] == 2'b11);
  endtask
  task automatic scramble(input logic [W-1:0] p, output logic [W-1:0] c);
    logic [NL-1:0] b;
    c = p;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < NL; k++) begin
        b[k] = p[66*k+i] ^ th[th.size()-39][k] ^ th[th.size()-58][k];
        c[66*k+i] = b[k];
      end
      th.push_back(b);
      void'(th.pop_front());
    end
  endtask
  task automatic tx_push(input logic [W-1:0] c);
    logic [NL-1:0] b;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < NL; k++) b[k] = c[66*k+i];
      th.push_back(b);
      void'(th.pop_front());
    end
  endtask
  function automatic logic [W-1:0] rnd_blk(input bit vh);
    logic [W-1:0] b;
    logic [1:0] h;
    for (int k = 0; k < NL; k++) begin
      b[66*k +: 32] = $urandom;
      b[66*k+32 +: 32] = $urandom;
      h = 2'($urandom);
      if (vh) h = {h[0], ~h[0]};
      b[66*k+64 +: 2] = h;
    end
    return b;
  endfunction
  // mode 0: model expectation, 1: supplied expectation, 2: don't care
  task automatic send(input logic [W-1:0] d, input logic byp, input int mode, input logic [W-1:0] pexp);
    logic [W-1:0] e;
    logic [NL-1:0] he;
    exp_t x;
    bit a;
    int t = 0;
    bus.data_in = d;
    bypass = byp;
    bus.data_valid_in = 1'b1;
    do begin
      @(negedge rx_clk);
      a = bus.data_ready_out;
      if (err_cnt_clr) cnt_m = 0;
      if (a) begin
        model(d, byp, e, he);
        if (!err_cnt_clr) cnt_m = (cnt_m + $countones(he) > MAXC) ? MAXC : cnt_m + $countones(he);
        x.d = (mode == 1) ? pexp : e;
        x.he = he;
        x.dc = (mode == 2);
        sb.push_back(x);
      end
      @(posedge rx_clk);
      #1;
      t++;
    end while (!a && t < 200);
    if (!a) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout got no ready expected ready within 200 cycles");
    end
  endtask
  task automatic drain();
    int t = 0;
    bus.data_valid_in = 1'b0;
    rdy_rand = 0;
    rdy_force = 1;
    while ((sb.size() != 0 || occ != 0) && t < 100) begin
      @(posedge rx_clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
    end
    @(posedge rx_clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge rx_clk);
    #1 rx_rst = 1'b1;
    sb.delete();
    rh.delete();
    for (int i = 0; i < 58; i++) rh.push_back('1);
    occ = 0;
    stall = 0;
    cnt_m = 0;
    #1;
    chk("rst_valid_out", W'(bus.data_valid_out), W'(0));
    chk("rst_data_out", bus.data_out, W'(0));
    chk("rst_hdr_err", W'(bus.hdr_err_out), W'(0));
    chk("rst_err_cnt", W'(err_cnt), W'(0));
    chk("rst_ready_out", W'(bus.data_ready_out), W'(1));
    #2 rx_rst = 1'b0;
    @(posedge rx_clk);
    #1;
  endtask
  initial forever begin
    @(posedge rx_clk);
    #2 bus.data_ready_in = rdy_rand ? ($urandom_range(0, 9) >= 3) : rdy_force;
  end
  initial forever begin
    @(negedge rx_clk);
    if (!rx_rst) begin
      if (stall) begin
        chk("stall_valid", W'(bus.data_valid_out), W'(1));
        chk("stall_data", bus.data_out, prev_d);
        chk("stall_herr", W'(bus.hdr_err_out), W'(prev_h));
      end
      chk("ready_out", W'(bus.data_ready_out), W'(occ < 2));
      chk("valid_out", W'(bus.data_valid_out), W'(occ > 0));
      if (bus.data_valid_out && bus.data_ready_in) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_beat got %h expected none", bus.data_out);
        end else begin
          me = sb.pop_front();
          if (!me.dc) begin
            chk("data_out", bus.data_out, me.d);
            chk("hdr_err_out", W'(bus.hdr_err_out), W'(me.he));
          end
        end
      end
      occ = occ + int'(bus.data_valid_in && bus.data_ready_out) - int'(bus.data_valid_out && bus.data_ready_in);
      stall = bus.data_valid_out && !bus.data_ready_in;
      prev_d = bus.data_out;
      prev_h = bus.hdr_err_out;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [W-1:0] z, s1, p, c, d, eb;
    bus.data_in = '0;
    bus.data_valid_in = 1'b0;
    bus.data_ready_in = 1'b1;
    z = '0;
    for (int k = 0; k < NL; k++) begin
      z[66*k +: 66] = {2'b01, 64'h0};
      s1[66*k +: 66] = {2'b01, 64'h03FF_FF80_0000_0000};
    end
    do_reset();
    send(z, 1'b0, 1, s1);
    send(z, 1'b0, 1, z);
    drain();
    do_reset();
    th.delete();
    for (int i = 0; i < 58; i++) th.push_back(NL'($urandom));
    for (int b = 0; b < 20; b++) begin
      p = rnd_blk(1);
      scramble(p, c);
      send(c, 1'b0, (b == 0) ? 2 : 1, p);
    end
    for (int k = 0; k < NL; k++) d[66*k +: 66] = {2'b10, 64'hDEAD_BEEF_0123_4567};
    send(d, 1'b1, 1, d);
    tx_push(d);
    for (int b = 0; b < 3; b++) begin
      p = rnd_blk(1);
      scramble(p, c);
      send(c, 1'b0, 1, p);
    end
    drain();
    do_reset();
    eb = rnd_blk(1);
    eb[64 +: 2] = 2'b00;
    eb[66+64 +: 2] = 2'b01;
    eb[132+64 +: 2] = 2'b11;
    eb[198+64 +: 2] = 2'b10;
    send(eb, 1'b0, 0, '0);
    chk("hdr_err_0101", W'(bus.hdr_err_out), W'(4'b0101));
    chk("err_cnt_2", W'(err_cnt), W'(2));
    for (int j = 2; j <= 9; j++) begin
      send(eb, 1'b0, 0, '0);
      chk("err_cnt_sat", W'(err_cnt), W'((2*j > 15) ? 15 : 2*j));
    end
    err_cnt_clr = 1'b1;
    send(eb, 1'b0, 0, '0);
    err_cnt_clr = 1'b0;
    chk("err_cnt_clr", W'(err_cnt), W'(0));
    send(eb, 1'b0, 0, '0);
    chk("err_cnt_after_clr", W'(err_cnt), W'(cnt_m));
    drain();
    rdy_rand = 1;
    for (int b = 0; b < 1000; b++) send(rnd_blk(0), $urandom_range(0, 3) == 0, 0, '0);
    drain();
    chk("err_cnt_random", W'(err_cnt), W'(cnt_m));
    rdy_force = 0;
    @(posedge rx_clk);
    #1;
    send(eb, 1'b0, 0, '0);
    send(eb, 1'b0, 0, '0);
    bus.data_valid_in = 1'b0;
    chk("skid_full_ready", W'(bus.data_ready_out), W'(0));
    rdy_force = 1;
    do_reset();
    send(z, 1'b0, 1, s1);
    drain();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/multilane_self_sync_descrambler.md
Name: multilane_self_sync_descrambler

Overview:
Parametrised receive-side 64b/66b descrambler for the PCS. It runs one self-synchronising x^58+x^39+1 descrambler per lane over NUM_LANES parallel 66-bit blocks. It sits between block lock / gearbox and the 66b decoder. Added over the single-lane block:
- multi-lane support
- self-synchronisation from received bits
- a registered-ready skid buffer
- a bypass mode
- per-lane sync-header error flags and a saturating error counter

Parameters:
NUM_LANES, 1, number of parallel 66-bit lanes (1..8).
ERR_CNT_W, 16, width of the header error counter.

Ports:
rx_clk  in  1  receive clock; all logic on its rising edge.
rx_rst  in  1  asynchronous, active-high reset.
data_in  in  66*NUM_LANES  lane k occupies [66k+65:66k]; sync header in [66k+65:66k+64]; payload bit 0 is first on the wire.
data_valid_in  in  1  upstream beat valid.
data_ready_out  out  1  registered ready to upstream.
bypass  in  1  1 = payload is passed through without descrambling.
err_cnt_clr  in  1  synchronous clear of err_cnt.
data_out  out  66*NUM_LANES  descrambled blocks, same lane layout as data_in.
hdr_err_out  out  NUM_LANES  per-lane flag, aligned with data_out: header was 00 or 11.
data_valid_out  out  1  downstream beat valid.
data_ready_in  in  1  downstream ready.
err_cnt  out  ERR_CNT_W  saturating count of invalid sync headers.

Behaviour:
Reset (rx_rst = 1, asynchronous):
- data_out = 0, hdr_err_out = 0, data_valid_out = 0.
- data_ready_out = 1 after reset.
- err_cnt = 0.
- All lane states = 58'h3FF_FFFF_FFFF_FFFF.
- Skid buffer empty.
- Reset asserted mid-stream discards any in-flight and skid contents immediately.

Accept and LFSR update:
- A beat is accepted when data_valid_in && data_ready_out.
- Lane state updates only on accept. For payload bits i = 0..63, in order:
  - out[i] = in[i] ^ s[38] ^ s[57]
  - then s = {s[56:0], in[i]}, where in[i] is the received (scrambled) bit.
- The state update is identical whatever the header value and whatever bypass is.
- Lanes are fully independent.

Output formation:
- Header: the output header equals the input header unchanged.
- Payload: descrambled payload when bypass = 0; in[63:0] unchanged when bypass = 1.
- bypass is sampled at accept time.
- Because the state always tracks received bits, toggling bypass needs no resync.
- hdr_err_out[k] = (header == 2'b00 || header == 2'b11), computed at accept time and carried with the beat.
- An invalid header does not stop descrambling.

Self-synchronisation:
- Any 58 consecutive received payload bits fully determine the state.
- Therefore the second accepted block per lane after reset is always correct regardless of seed.

Error counter:
- On accept, err_cnt += popcount(hdr_err of the beat), saturating at 2^ERR_CNT_W-1.
- err_cnt_clr has priority: that cycle err_cnt becomes 0 and the same cycle's errors are dropped.

Pipeline and handshake:
- 1-cycle latency: an accepted beat appears on data_out the next cycle if the output register is free or draining.
- Output register plus one skid register.
- data_ready_out = !skid_full, and is registered.
- Output stalled (data_valid_out && !data_ready_in) while a beat is accepted: the beat goes to skid and data_ready_out drops the next cycle.
- When the output drains, skid moves to the output register and ready re-asserts the next cycle.
- data_out and hdr_err_out hold stable while data_valid_out && !data_ready_in.
- No beat is lost or duplicated under any valid/ready pattern.
- Simultaneous drain of output and accept of a new beat with skid empty: the new beat loads the output register directly.

Test Plan:
1. Seed check, NUM_LANES=1, bypass=0: after reset, send header 01 with payload 64'h0.
   - Required data_out payload 64'h03FF_FF80_0000_0000, header 01, hdr_err_out=0.
   - Send the same block again: required payload 64'h0.
2. Self-sync: after reset, send 20 blocks scrambled by the bench model from a random seed.
   - Blocks 2..20 must match the original plaintext exactly.
   - Block 1 is don't-care.
3. Bypass: bypass=1, send header 10 with payload 64'hDEAD_BEEF_0123_4567.
   - Output must be identical.
   - Drop bypass mid-stream: the next block is correctly descrambled with no resync gap.
4. Header errors, NUM_LANES=4: a beat with lane headers {00,01,11,10} gives hdr_err_out=4'b0101 and err_cnt +2.
   - With ERR_CNT_W=4, repeat until err_cnt saturates at 15 and holds.
   - err_cnt_clr together with an error beat gives err_cnt=0.
5. Backpressure: random data_ready_in (30% low) over 1000 beats with continuous data_valid_in.
   - Output sequence must equal the reference model.
   - data_ready_out falls only after skid fill.
   - Outputs are stable while stalled.
6. Async reset: assert rx_rst for less than one cycle mid-stream with a full skid.
   - Outputs clear immediately, data_valid_out=0, err_cnt=0.
   - The first post-reset block reproduces the scenario 1 value.
